// File: rtl/ice_bus_pkg.sv
// ice_bus_pkg: shared character width, arbiter state type and clog2 helper
package ice_bus_pkg;
  localparam int ICE_CHAR_W = 8;
  typedef enum logic {IDLE, GRANT} arb_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ice_arb_fifo.sv
// ice_arb_fifo: synchronous byte FIFO with wrap-bit pointers, async active-high reset
module ice_arb_fifo
  import ice_bus_pkg::*;
#(
  parameter int WIDTH = ICE_CHAR_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o
);
  localparam int AW = clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  // full/empty from the wrap bit; a pop frees the slot a same-cycle push needs
  always_comb begin
    empty_o = wr_q == rd_q;
    full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = wr_q + (AW+1)'(do_push);
    rd_d    = rd_q + (AW+1)'(do_pop);
    dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end
  // pointer registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  // storage array, contents need no reset since pointers define validity
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/ice_bus_rr_arbiter.sv
// ice_bus_rr_arbiter: round-robin return-path arbiter muxing slave bytes into a FIFO toward the UART
module ice_bus_rr_arbiter
  import ice_bus_pkg::*;
#(
  parameter int NUM_DEV     = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DEV-1:0]            sl_arb_request_i,
  output logic [NUM_DEV-1:0]            sl_arb_grant_o,
  input  logic [ICE_CHAR_W*NUM_DEV-1:0] sl_data_i,
  input  logic [NUM_DEV-1:0]            sl_data_latch_i,
  output logic                          sl_overflow_o,
  output logic                          arb_error_o,
  output logic                          grant_timeout_o,
  output logic [ICE_CHAR_W-1:0]         tx_char_o,
  output logic                          tx_char_valid_o,
  input  logic                          tx_char_ready_i
);
  localparam int PW = (NUM_DEV > 1) ? clog2(NUM_DEV) : 1;

  function automatic logic [PW-1:0] rr_pick(input logic [NUM_DEV-1:0] av, input logic [PW-1:0] p);
    logic [PW-1:0] r;
    logic f;
    int j;
    r = '0;
    f = 1'b0;
    for (int k = 0; k < NUM_DEV; k++) begin
      j = (int'(p) + k) % NUM_DEV;
      if (!f && av[j]) begin
        r = PW'(j);
        f = 1'b1;
      end
    end
    return r;
  endfunction

  arb_state_e state_q;
  logic [PW-1:0] owner_q, ptr_q, pick, nxt;
  logic [NUM_DEV-1:0] grant_q, mask_q, avail;
  logic [31:0] timer_q, timer_d;
  logic own_lat, bad_lat, pop, full, empty, ovf, drop, tmo;
  logic ovf_q, err_q, tmo_q;
  logic [ICE_CHAR_W-1:0] own_byte;

  // request selection, latch classification and timer next value
  always_comb begin
    avail    = sl_arb_request_i & ~mask_q;
    pick     = rr_pick(avail, ptr_q);
    nxt      = (owner_q == PW'(NUM_DEV-1)) ? '0 : owner_q + PW'(1);
    own_lat  = |(sl_data_latch_i & grant_q);
    bad_lat  = |(sl_data_latch_i & ~grant_q);
    own_byte = sl_data_i[ICE_CHAR_W*owner_q +: ICE_CHAR_W];
    pop      = !empty && tx_char_ready_i;
    ovf      = own_lat && full && !pop;
    drop     = (state_q == GRANT) && !sl_arb_request_i[owner_q];
    timer_d  = own_lat ? '0 : timer_q + 32'(timer_q != '1);
    tmo      = (state_q == GRANT) && !drop && (TIMEOUT_CYC != 0) && (timer_d == 32'(TIMEOUT_CYC));
  end

  // arbiter FSM with registered grant and event pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      mask_q  <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      ovf_q  <= ovf;
      err_q  <= bad_lat;
      tmo_q  <= tmo;
      mask_q <= (mask_q & sl_arb_request_i) | (tmo ? grant_q : '0);
      if (state_q == IDLE) begin
        timer_q <= '0;
        if (|avail) begin
          state_q <= GRANT;
          owner_q <= pick;
          grant_q <= NUM_DEV'(1) << pick;
        end
      end else if (drop || tmo) begin
        state_q <= IDLE;
        grant_q <= '0;
        ptr_q   <= nxt;
        timer_q <= '0;
      end else begin
        timer_q <= timer_d;
      end
    end

  ice_arb_fifo #(.WIDTH(ICE_CHAR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (own_lat),
    .din_i  (own_byte),
    .full_o (full),
    .pop_i  (pop),
    .dout_o (tx_char_o),
    .empty_o(empty)
  );

  assign sl_arb_grant_o  = grant_q;
  assign sl_overflow_o   = ovf_q;
  assign arb_error_o     = err_q;
  assign grant_timeout_o = tmo_q;
  assign tx_char_valid_o = !empty;
endmodule
